// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
//   state_e       : controller state encoding (IDLE, RUN)
//   MODE_*        : values of the is_signed request input
//   abs_val()     : two's-complement magnitude. Callers sign-extend the
//                   operand to ABS_MAX_W bits and truncate the result back
//                   to their own width.
package mult_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  localparam int unsigned ABS_MAX_W = 64;

  // The most negative value maps to itself, which is its correct unsigned
  // magnitude once the result is truncated to the operand width.
  function automatic logic [ABS_MAX_W-1:0] abs_val(input logic [ABS_MAX_W-1:0] x);
    return x[ABS_MAX_W-1] ? (~x + ABS_MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/seq_mult_unit_if.sv
// Request/response bundle for seq_mult_unit.
//   master : drives start, is_signed, multiplicand, multiplier
//   slave  : drives busy, done, product_hi, product_lo
interface seq_mult_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  busy, done, product_hi, product_lo
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output busy, done, product_hi, product_lo
  );

endinterface

// File: rtl/mult_pp_step.sv
// One partial-product step: mcand * digit, aligned to bit cnt*BPC.
//   mcand : multiplicand magnitude (WIDTH)
//   digit : current BPC-bit multiplier digit
//   cnt   : iteration index
//   pp_c  : aligned partial product (2*WIDTH), combinational
module mult_pp_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1,
  parameter int unsigned CNT_W = 5
) (
  input  logic [WIDTH-1:0]   mcand,
  input  logic [BPC-1:0]     digit,
  input  logic [CNT_W-1:0]   cnt,
  output logic [2*WIDTH-1:0] pp_c
);

  localparam int unsigned P_W  = 2 * WIDTH;
  localparam int unsigned SH_W = $clog2(P_W);

  logic [P_W-1:0]  prod_c;
  logic [SH_W-1:0] shamt_c;

  // cnt*BPC < WIDTH, so the shift amount always fits in SH_W bits
  always_comb begin
    prod_c  = P_W'(mcand) * P_W'(digit);
    shamt_c = SH_W'(cnt) * SH_W'(BPC);
    pp_c    = prod_c << shamt_c;
  end

endmodule

// File: rtl/seq_mult_unit.sv
// Iterative shift-add multiplier for the HI/LO multiply path.
// It retires BPC multiplier bits per cycle and takes exactly WIDTH/BPC
// cycles from the accepted start to done.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.start, is_signed, multiplicand, multiplier : request, sampled while idle
//   bus.busy       : operation in progress
//   bus.done       : one-cycle completion pulse
//   bus.product_hi : upper half of the product
//   bus.product_lo : lower half of the product
module seq_mult_unit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_mult_unit_if.slave bus
);

  localparam int unsigned N     = WIDTH / BPC;
  localparam int unsigned P_W   = 2 * WIDTH;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!(BPC == 1 || BPC == 2 || BPC == 4) || (WIDTH % BPC) != 0 ||
      WIDTH > ABS_MAX_W) begin : g_param_check
    $error("seq_mult_unit: illegal WIDTH/BPC combination");
  end

  state_e             state_q, state_d;
  logic               accept_c, finish_c;
  logic [WIDTH-1:0]   mcand_q, mplier_q;
  logic               neg_q;
  logic [P_W-1:0]     acc_q, acc_next_c, pp_c;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   a_mag_c, b_mag_c;
  logic               signed_req_c;

  // Operand magnitudes for signed requests
  assign signed_req_c = (bus.is_signed == MODE_SIGNED);
  assign a_mag_c = WIDTH'(abs_val(ABS_MAX_W'($signed(bus.multiplicand))));
  assign b_mag_c = WIDTH'(abs_val(ABS_MAX_W'($signed(bus.multiplier))));

  mult_pp_step #(
    .WIDTH (WIDTH),
    .BPC   (BPC),
    .CNT_W (CNT_W)
  ) u_pp_step (
    .mcand (mcand_q),
    .digit (mplier_q[BPC-1:0]),
    .cnt   (cnt_q),
    .pp_c  (pp_c)
  );

  assign acc_next_c = acc_q + pp_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is only looked at while idle
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          accept_c = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d  = IDLE;
          finish_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath, handshake and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      busy_q <= (state_d == RUN);
      done_q <= finish_c;
      if (accept_c) begin
        mcand_q  <= signed_req_c ? a_mag_c : bus.multiplicand;
        mplier_q <= signed_req_c ? b_mag_c : bus.multiplier;
        neg_q    <= signed_req_c &
                    (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == RUN) begin
        acc_q    <= acc_next_c;
        mplier_q <= mplier_q >> BPC;
        cnt_q    <= cnt_q + CNT_W'(1);
        // Sign fix-up folds into the final accumulate
        if (finish_c) begin
          {hi_q, lo_q} <= neg_q ? (~acc_next_c + P_W'(1)) : acc_next_c;
        end
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.product_hi = hi_q;
  assign bus.product_lo = lo_q;

endmodule
